// File: rtl/imem_loader_pkg.sv
// Shared processor constants and loader state encoding.
// IMEM_DEPTH is shared by the boot loader and the instruction memory so that they stay in step.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian shift assembler; the first byte of a word ends up in the MSB.
// Latency: word/word_valid are combinational on the 4th accepted byte, so the caller can register them at that same edge.
// Backpressure: none of its own; it counts only the bytes that the caller reports as transferred.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_fire,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] acc;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (byte_fire) begin
      acc <= {acc[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  // The current byte is appended here rather than stored, so the full word is ready on the 4th transfer.
  assign word       = {acc, byte_in};
  assign word_valid = byte_fire && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit words and writes them to instruction memory from address 0, stalling the CPU meanwhile.
// Latency: the write cycle follows the 4th accepted byte by one clock; done rises one cycle after the last write.
// Backpressure: byte_ready is high only in RECV, so bytes are refused during the write cycle and when no load is active.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_stall,
  output logic             done,
  output logic             error
);

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] word_idx;
  logic             byte_fire;
  logic             word_vld;
  logic [31:0]      word;
  logic             idle_like;
  logic             start_ok;
  logic             last_word;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign byte_ready = (state == RECV);
  assign cpu_stall  = (state == RECV) || (state == WRITE);
  assign byte_fire  = byte_valid && byte_ready;
  assign start_ok   = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
  assign last_word  = ((word_idx + CNT_W'(1)) == cnt_q);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (idle_like && start && start_ok),
    .byte_fire  (byte_fire),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = start_ok ? RECV : DONE;
      RECV:       if (word_vld) state_nxt = WRITE;
      WRITE:      state_nxt = last_word ? DONE : RECV;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done <= 1'b0;
            if (start_ok) begin
              cnt_q    <= num_words;
              word_idx <= '0;
              error    <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RECV: begin
          // Write-port registers are loaded on the 4th byte so they are stable for the entire WRITE cycle.
          if (word_vld) begin
            wr_en   <= 1'b1;
            wr_addr <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
            wr_data <= word;
          end
        end
        WRITE: begin
          word_idx <= word_idx + CNT_W'(1);
          if (last_word) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: timing of a single word, gapped multi-word loads, bad counts, full depth, reset mid-load, and restart.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_stall;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa [0:255];
  logic [31:0] wd [0:255];
  int          wr_cnt = 0;
  int          rdy_cnt = 0;

  imem_loader #(.DEPTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write-port and byte_ready monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa[wr_cnt[7:0]] <= wr_addr;
      wd[wr_cnt[7:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (byte_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_rise", 32'(done), 32'd1);
  endtask

  logic [31:0] six [0:5];
  int base;
  int rbase;
  logic [31:0] w;
  logic [7:0]  iv;

  initial begin
    six[0] = 32'h01897020; six[1] = 32'h01C96020; six[2] = 32'h01CE5820;
    six[3] = 32'h012A7822; six[4] = 32'h03197822; six[5] = 32'h01F8C820;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word with exact cycle timing
    do_start(5'd1);
    base = wr_cnt;
    check("one_ready_after_start", 32'(byte_ready), 32'd1);
    check("one_stall_after_start", 32'(cpu_stall), 32'd1);
    send_word(32'h01897020, 0);
    check("one_wr_en", 32'(wr_en), 32'd1);
    check("one_wr_addr", wr_addr, 32'h0);
    check("one_wr_data", wr_data, 32'h01897020);
    check("one_ready_in_write", 32'(byte_ready), 32'd0);
    check("one_stall_in_write", 32'(cpu_stall), 32'd1);
    check("one_done_in_write", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("one_wr_en_after", 32'(wr_en), 32'd0);
    check("one_done", 32'(done), 32'd1);
    check("one_stall_fall", 32'(cpu_stall), 32'd0);
    check("one_wr_data_hold", wr_data, 32'h01897020);
    check("one_write_count", 32'(wr_cnt - base), 32'd1);

    // Six words with random valid gaps
    do_start(5'd6);
    base = wr_cnt;
    for (int i = 0; i < 6; i++) send_word(six[i], 3);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("six_write_count", 32'(wr_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("six_addr%0d", i), wa[base+i], 32'(i * 4));
      check($sformatf("six_data%0d", i), wd[base+i], six[i]);
    end

    // Bad counts: 0 and DEPTH+1
    for (int t = 0; t < 2; t++) begin
      base = wr_cnt;
      rbase = rdy_cnt;
      byte_valid = 1'b1;
      byte_in = 8'hFF;
      do_start((t == 0) ? 5'd0 : 5'd17);
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("bad%0d_error", t), 32'(error), 32'd1);
      check($sformatf("bad%0d_done", t), 32'(done), 32'd0);
      check($sformatf("bad%0d_stall", t), 32'(cpu_stall), 32'd0);
      check($sformatf("bad%0d_no_ready", t), 32'(rdy_cnt - rbase), 32'd0);
      check($sformatf("bad%0d_no_write", t), 32'(wr_cnt - base), 32'd0);
      byte_valid = 1'b0;
    end

    // Full depth
    do_start(5'd16);
    check("full_error_cleared", 32'(error), 32'd0);
    base = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      iv = 8'(i);
      send_word({iv, 8'hA5, ~iv, 8'h3C}, 0);
    end
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    check("full_write_count", 32'(wr_cnt - base), 32'd16);
    check("full_last_addr", wa[base+15], 32'h3C);
    check("full_last_data", wd[base+15], 32'h0FA5F03C);
    check("full_addr7", wa[base+7], 32'h1C);
    check("full_data7", wd[base+7], 32'h07A5F83C);

    // Reset during word 3
    do_start(5'd4);
    base = wr_cnt;
    for (int i = 0; i < 3; i++) send_word(32'hC0DE0000 | 32'(i), 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_byte_ready", 32'(byte_ready), 32'd0);
    check("mrst_wr_en", 32'(wr_en), 32'd0);
    check("mrst_wr_addr", wr_addr, 32'd0);
    check("mrst_wr_data", wr_data, 32'd0);
    check("mrst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_prior_writes", 32'(wr_cnt - base), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(5'd1);
    base = wr_cnt;
    send_word(32'hDEADBEEF, 0);
    wait_done();
    #1;
    check("mrst_restart_count", 32'(wr_cnt - base), 32'd1);
    check("mrst_restart_addr", wa[base], 32'h0);
    check("mrst_restart_data", wd[base], 32'hDEADBEEF);

    // Start during RECV is ignored
    do_start(5'd2);
    base = wr_cnt;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(5'd1);
    check("ign_still_stalled", 32'(cpu_stall), 32'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'h55667788, 1);
    wait_done();
    #1;
    check("ign_write_count", 32'(wr_cnt - base), 32'd2);
    check("ign_addr0", wa[base], 32'h0);
    check("ign_data0", wd[base], 32'h11223344);
    check("ign_addr1", wa[base+1], 32'h4);
    check("ign_data1", wd[base+1], 32'h55667788);

    // Restart after done overwrites from address 0
    do_start(5'd2);
    check("rs_done_cleared", 32'(done), 32'd0);
    check("rs_stall", 32'(cpu_stall), 32'd1);
    base = wr_cnt;
    send_word(32'hA1B2C3D4, 2);
    send_word(32'h0F1E2D3C, 2);
    wait_done();
    #1;
    check("rs_write_count", 32'(wr_cnt - base), 32'd2);
    check("rs_addr0", wa[base], 32'h0);
    check("rs_data0", wd[base], 32'hA1B2C3D4);
    check("rs_addr1", wa[base+1], 32'h4);
    check("rs_data1", wd[base+1], 32'h0F1E2D3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
